hardwired_control_unit: RTL
===========================

Name: hardwired_control_unit

Overview:
- Instruction-sequencing controller that drives every control input of ALU_System, replacing the test-vector driver.
- Fetches a 16-bit instruction as two bytes from memory at PC into IR (low byte, then high byte).
- Decodes the instruction and issues one or two execute cycles of register, ALU, memory and mux controls.
- Sits beside ALU_System; its only feedback is IROut and the ALU flags.

Parameters:
None. Widths are fixed by ALU_System: 8-bit data/address, 16-bit instruction.

Ports:
Clock  in  1  system clock, all state updates on posedge
Reset  in  1  synchronous, active-low reset
IROut  in  16  instruction register contents
ALU_Flag  in  4  latched ALU flags {Z,C,N,O}, bit3=Z
RF_OutASel, RF_OutBSel  out  3 each  000..011 select R1..R4
RF_FunSel  out  2  register function
RF_RSel  out  4  one-hot R1..R4 enable, bit3=R1, active-high
RF_TSel  out  4  temp enables; always 0000
ALU_FunSel  out  4  ALU operation
ARF_OutCSel, ARF_OutDSel  out  2 each  00 PC, 01 AR, 10 SP; OutD is the memory address
ARF_FunSel  out  2  register function
ARF_RegSel  out  4  enables: bit3 PC, bit2 AR, bit1 SP, bit0 unused
IR_LH  out  1  0 = load low byte, 1 = load high byte
IR_Enable  out  1  IR write enable
IR_Funsel  out  2  IR function
Mem_WR  out  1  1 = write
Mem_CS  out  1  chip select, active-low
MuxASel  out  2  RF input: 00 ALUOut, 01 MemOut, 10 IROut[7:0], 11 ARF OutC
MuxBSel  out  2  ARF input: same encoding as MuxASel
MuxCSel  out  1  ALU A input: 0 RF AOut, 1 ARF OutC
SeqCount  out  2  current step T0..T3
Halted  out  1  processor halted

Behaviour:
- Fixed encodings:
  - FunSel (all registers): 00 clear, 01 load, 10 decrement, 11 increment.
  - ALU_FunSel: 0000 pass A, 0010 NOT A, 0100 A+B, 0101 A-B, 0111 A&B, 1000 A|B.
- Instruction word = {high byte, low byte} = IR[15:12] OP, IR[11:10] Rd, IR[9:8] Rs, IR[7:0] IMM.
- State: 2-bit sequence counter SC plus a Halted flag. Controls are combinational from SC, IROut, ALU_Flag and Halted. Destinations capture them at the posedge ending the cycle.
- Idle default, applied unless a step overrides it:
  - all enables 0, Mem_CS=1, Mem_WR=0;
  - all selects and FunSels 0.
- Reset=0 during a cycle:
  - outputs RF_RSel=1111 with RF_FunSel=00, ARF_RegSel=1000 with ARF_FunSel=00, everything else idle;
  - at the posedge: SC<=T0, Halted<=0, so PC=0 and R1..R4=0.
  - Reset mid-instruction aborts it; no memory write occurs in a reset cycle.
- T0 (fetch low):
  - ARF_OutDSel=00, Mem_CS=0, IR_Enable=1, IR_LH=0, IR_Funsel=01;
  - ARF_RegSel=1000, ARF_FunSel=11 (PC++);
  - SC<=T1.
- T1 (fetch high): same as T0 with IR_LH=1; SC<=T2.
- T2 (execute):
  - 0 LDI: MuxASel=10, RF_RSel=Rd, RF_FunSel=01.
  - 1 LD / 2 ST: MuxBSel=10, ARF_RegSel=0100, ARF_FunSel=01; SC<=T3.
  - 3 MOV: OutASel=Rs, MuxCSel=0, ALU 0000, MuxASel=00, load Rd.
  - 4 ADD / 5 SUB / 6 AND / 7 OR: OutASel=Rd, OutBSel=Rs, MuxCSel=0, ALU op, MuxASel=00, load Rd.
  - 8 BRA: MuxBSel=10, ARF_RegSel=1000, ARF_FunSel=01.
  - 9 BEQ: as BRA if Z=1, else idle.
  - A BNE: as BRA if Z=0, else idle.
  - B INC / C DEC: RF_RSel=Rd, RF_FunSel=11 / 10.
  - D, E NOP: idle.
  - F HLT: Halted<=1.
  - All opcodes except LD/ST: SC<=T0.
- T3 (LD/ST only; SC<=T0):
  - LD: ARF_OutDSel=01, Mem_CS=0, MuxASel=01, load Rd.
  - ST: ARF_OutDSel=01, OutASel=Rd, MuxCSel=0, ALU 0000, Mem_CS=0, Mem_WR=1.
- Halted=1: idle outputs, SC holds T0, PC frozen. Only Reset=0 leaves this state.
- SC=T3 with a non-LD/ST opcode is unreachable; if it occurs, drive idle and set SC<=T0.
- Instruction length: every instruction is exactly 3 clocks, except LD/ST which take 4.

Test Plan:
- Hold Reset=0 one cycle with R1..R4 and PC nonzero -> PC=0x00, R1..R4=0x00, SeqCount=0, Halted=0, no Mem_WR pulse.
- M[0]=0x5A, M[1]=0x04 (LDI R2,0x5A) -> after 3 clocks R2=0x5A, PC=0x02, IROut=0x045A.
- M[0]=0x20, M[1]=0x10 (LD R1), M[0x20]=0x33; then M[2]=0x21, M[3]=0x20 (ST R1) -> R1=0x33 after clock 4, M[0x21]=0x33 after clock 8, AR=0x21, PC=0x04.
- R1=0x03, R2=0x04, word 0x4100 (ADD R1,R2) -> R1=0x07 and R2 unchanged after 3 clocks; word 0x5100 with R1=R2 -> Z=1.
- BEQ word 0x9040: Z=1 -> PC=0x40; Z=0 -> PC=fetch address+2. BNE word 0xA040 gives the opposite outcome.
- HLT word 0xF000 -> Halted=1; for 10 further clocks PC is constant, IR_Enable=0, Mem_CS=1; Reset=0 for one cycle -> Halted=0, fetch restarts at 0x00.
- Reset=0 asserted during the T3 of an ST -> memory unchanged, SC=0 at the next cycle.

Source files
------------

// File: rtl/hardwired_control_unit.sv
// ============================================================================
// Module  : hardwired_control_unit
// Brief   : Fetch/decode/execute sequencer driving every ALU_System control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hardwired_control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALU_Flag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [1:0]  SeqCount,
  output logic        Halted
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } seq_t;

  localparam logic [1:0] c_fun_clr  = 2'b00;
  localparam logic [1:0] c_fun_load = 2'b01;
  localparam logic [1:0] c_fun_dec  = 2'b10;
  localparam logic [1:0] c_fun_inc  = 2'b11;

  localparam logic [3:0] c_op_ldi = 4'h0;
  localparam logic [3:0] c_op_ld  = 4'h1;
  localparam logic [3:0] c_op_st  = 4'h2;
  localparam logic [3:0] c_op_mov = 4'h3;
  localparam logic [3:0] c_op_add = 4'h4;
  localparam logic [3:0] c_op_sub = 4'h5;
  localparam logic [3:0] c_op_and = 4'h6;
  localparam logic [3:0] c_op_or  = 4'h7;
  localparam logic [3:0] c_op_bra = 4'h8;
  localparam logic [3:0] c_op_beq = 4'h9;
  localparam logic [3:0] c_op_bne = 4'hA;
  localparam logic [3:0] c_op_inc = 4'hB;
  localparam logic [3:0] c_op_dec = 4'hC;
  localparam logic [3:0] c_op_hlt = 4'hF;

  seq_t        r_sc, w_sc_next;
  logic        r_halted, w_halted_next;
  logic [3:0]  w_op;
  logic [1:0]  w_rd, w_rs;
  logic [3:0]  w_rd_onehot;
  logic        w_zero;
  logic        w_unused_bits;

  assign w_op          = IROut[15:12];
  assign w_rd          = IROut[11:10];
  assign w_rs          = IROut[9:8];
  assign w_rd_onehot   = 4'b1000 >> w_rd;
  assign w_zero        = ALU_Flag[3];
  // The immediate reaches the datapath through MuxA/MuxB, not through here.
  assign w_unused_bits = ^{ALU_Flag[2:0], IROut[7:0]};

  assign SeqCount = r_sc;
  assign Halted   = r_halted;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_sc     <= T0;
      r_halted <= 1'b0;
    end else begin
      r_sc     <= w_sc_next;
      r_halted <= w_halted_next;
    end
  end

  always_comb begin
    RF_OutASel    = 3'b000;
    RF_OutBSel    = 3'b000;
    RF_FunSel     = c_fun_clr;
    RF_RSel       = 4'b0000;
    RF_TSel       = 4'b0000;
    ALU_FunSel    = 4'b0000;
    ARF_OutCSel   = 2'b00;
    ARF_OutDSel   = 2'b00;
    ARF_FunSel    = c_fun_clr;
    ARF_RegSel    = 4'b0000;
    IR_LH         = 1'b0;
    IR_Enable     = 1'b0;
    IR_Funsel     = 2'b00;
    Mem_WR        = 1'b0;
    Mem_CS        = 1'b1;
    MuxASel       = 2'b00;
    MuxBSel       = 2'b00;
    MuxCSel       = 1'b0;
    w_sc_next     = r_sc;
    w_halted_next = r_halted;

    if (!Reset) begin
      // Clear R1..R4 and PC in the same cycle the sequencer returns to T0.
      RF_RSel    = 4'b1111;
      ARF_RegSel = 4'b1000;
    end else if (r_halted) begin
      w_sc_next = T0;
    end else begin
      case (r_sc)
        T0, T1: begin
          Mem_CS     = 1'b0;
          IR_Enable  = 1'b1;
          IR_LH      = (r_sc == T1);
          IR_Funsel  = c_fun_load;
          ARF_RegSel = 4'b1000;
          ARF_FunSel = c_fun_inc;
          w_sc_next  = (r_sc == T0) ? T1 : T2;
        end
        T2: begin
          w_sc_next = T0;
          case (w_op)
            c_op_ldi: begin
              MuxASel   = 2'b10;
              RF_RSel   = w_rd_onehot;
              RF_FunSel = c_fun_load;
            end
            c_op_ld, c_op_st: begin
              MuxBSel    = 2'b10;
              ARF_RegSel = 4'b0100;
              ARF_FunSel = c_fun_load;
              w_sc_next  = T3;
            end
            c_op_mov, c_op_add, c_op_sub, c_op_and, c_op_or: begin
              RF_OutASel = (w_op == c_op_mov) ? {1'b0, w_rs} : {1'b0, w_rd};
              RF_OutBSel = {1'b0, w_rs};
              case (w_op)
                c_op_add: ALU_FunSel = 4'b0100;
                c_op_sub: ALU_FunSel = 4'b0101;
                c_op_and: ALU_FunSel = 4'b0111;
                c_op_or:  ALU_FunSel = 4'b1000;
                default:  ALU_FunSel = 4'b0000;
              endcase
              RF_RSel   = w_rd_onehot;
              RF_FunSel = c_fun_load;
            end
            c_op_bra, c_op_beq, c_op_bne: begin
              if ((w_op == c_op_bra) || ((w_op == c_op_beq) == w_zero)) begin
                MuxBSel    = 2'b10;
                ARF_RegSel = 4'b1000;
                ARF_FunSel = c_fun_load;
              end
            end
            c_op_inc, c_op_dec: begin
              RF_RSel   = w_rd_onehot;
              RF_FunSel = (w_op == c_op_inc) ? c_fun_inc : c_fun_dec;
            end
            c_op_hlt: w_halted_next = 1'b1;
            default: ;
          endcase
        end
        default: begin
          w_sc_next   = T0;
          ARF_OutDSel = 2'b01;
          if (w_op == c_op_ld) begin
            Mem_CS    = 1'b0;
            MuxASel   = 2'b01;
            RF_RSel   = w_rd_onehot;
            RF_FunSel = c_fun_load;
          end else if (w_op == c_op_st) begin
            RF_OutASel = {1'b0, w_rd};
            Mem_CS     = 1'b0;
            Mem_WR     = 1'b1;
          end else begin
            ARF_OutDSel = 2'b00;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
